// File: rtl/sw_pkg.sv
// Shared constants and types for the 3x3 sliding-window front end.
// Default geometry; instances override through parameters.
package sw_pkg;

   localparam int DEF_PIX_W = 8;
   localparam int DEF_IMG_W = 256;
   localparam int DEF_IMG_H = 256;

   localparam int COL_W = $clog2(DEF_IMG_W);
   localparam int ROW_W = $clog2(DEF_IMG_H);

   typedef logic [DEF_PIX_W-1:0] pix_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sw_line_buffer.sv
// One image row of storage: combinational read, synchronous write.
// Read and write share one address so a pixel is swapped out in place.
module sw_line_buffer
   import sw_pkg::*;
#(
   parameter int DEPTH = DEF_IMG_W,
   parameter int PIX_W = DEF_PIX_W,
   parameter int AW    = cnt_w(DEPTH)
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sw_window_gen.sv
// Raster-to-3x3-window generator with two row line buffers.
// Optional SW_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module sw_window_gen
   import sw_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = DEF_PIX_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic             sof,
   output logic             act,
   output logic [PIX_W-1:0] sw_pixels1,
   output logic [PIX_W-1:0] sw_pixels2,
   output logic [PIX_W-1:0] sw_pixels3,
   output logic [PIX_W-1:0] sw_pixels4,
   output logic [PIX_W-1:0] sw_pixels5,
   output logic [PIX_W-1:0] sw_pixels6,
   output logic [PIX_W-1:0] sw_pixels7,
   output logic [PIX_W-1:0] sw_pixels8,
   output logic [PIX_W-1:0] sw_pixels9,
   output logic             frame_done
`ifdef SW_FRAME_CNT_EN
   ,output logic [15:0]     frame_cnt
`endif
);

   localparam int C_W = cnt_w(IMG_W);
   localparam int R_W = cnt_w(IMG_H);

   localparam logic [C_W-1:0] COL_LAST = C_W'(IMG_W - 1);
   localparam logic [R_W-1:0] ROW_LAST = R_W'(IMG_H - 1);
   localparam logic [C_W-1:0] COL_TWO  = C_W'(2);
   localparam logic [R_W-1:0] ROW_TWO  = R_W'(2);

   logic [C_W-1:0]   col;
   logic [C_W-1:0]   cur_col;
   logic [C_W-1:0]   nxt_col;
   logic [R_W-1:0]   row;
   logic [R_W-1:0]   cur_row;
   logic [R_W-1:0]   nxt_row;
   logic [PIX_W-1:0] a_rd;
   logic [PIX_W-1:0] b_rd;
   logic [PIX_W-1:0] win [9];
   logic             interior;
   logic             last_pix;

   // sof relabels the current pixel as (0,0), dropping any partial frame
   always_comb begin
      cur_col = sof ? '0 : col;
      cur_row = sof ? '0 : row;
      nxt_col = cur_col + 1'b1;
      nxt_row = cur_row;
      if (cur_col == COL_LAST) begin
         nxt_col = '0;
         nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end
   end

   assign interior = (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
   assign last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

   sw_line_buffer #(
      .DEPTH (IMG_W),
      .PIX_W (PIX_W),
      .AW    (C_W)
   ) lb_a (
      .clk   (clk),
      .we    (in_valid),
      .addr  (cur_col),
      .wdata (in_pixel),
      .rdata (a_rd)
   );

   sw_line_buffer #(
      .DEPTH (IMG_W),
      .PIX_W (PIX_W),
      .AW    (C_W)
   ) lb_b (
      .clk   (clk),
      .we    (in_valid),
      .addr  (cur_col),
      .wdata (a_rd),
      .rdata (b_rd)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         act        <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
      end else begin
         act        <= in_valid && interior;
         frame_done <= in_valid && last_pix;
         if (in_valid) begin
            col    <= nxt_col;
            row    <= nxt_row;
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= b_rd;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= a_rd;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_pixel;
         end
      end
   end

`ifdef SW_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (in_valid && last_pix) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

   assign sw_pixels1 = win[0];
   assign sw_pixels2 = win[1];
   assign sw_pixels3 = win[2];
   assign sw_pixels4 = win[3];
   assign sw_pixels5 = win[4];
   assign sw_pixels6 = win[5];
   assign sw_pixels7 = win[6];
   assign sw_pixels8 = win[7];
   assign sw_pixels9 = win[8];

endmodule

// File: tb/tb_sw_window_gen.sv
// Scoreboard bench for sw_window_gen on a 4x4 image.
// Frame-count checks build only with SW_FRAME_CNT_EN.
module tb_sw_window_gen;

   localparam int W = 4;
   localparam int H = 4;

   typedef struct {
      logic [71:0] win;
      logic        fd;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       sof;
   logic [7:0] in_pixel;
   logic       act;
   logic       frame_done;
   logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
`ifdef SW_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int   n_run   = 0;
   int   n_fail  = 0;
   int   act_cnt = 0;
   int   fd_cnt  = 0;
   int   mr      = 0;
   int   mc      = 0;
   int   a0;
   int   f0;
   logic [7:0] img [H][W];
   exp_t sb [$];
   exp_t got_e;

   always #5 clk = ~clk;

   sw_window_gen #(
      .IMG_W (W),
      .IMG_H (H),
      .PIX_W (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_pixel   (in_pixel),
      .sof        (sof),
      .act        (act),
      .sw_pixels1 (p1),
      .sw_pixels2 (p2),
      .sw_pixels3 (p3),
      .sw_pixels4 (p4),
      .sw_pixels5 (p5),
      .sw_pixels6 (p6),
      .sw_pixels7 (p7),
      .sw_pixels8 (p8),
      .sw_pixels9 (p9),
      .frame_done (frame_done)
`ifdef SW_FRAME_CNT_EN
      ,.frame_cnt (frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [71:0] got,
                      input logic [71:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] cur_win();
      return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
   endfunction

   always @(negedge clk) begin
      if (act) begin
         act_cnt++;
         if (sb.size() == 0) begin
            chk("spurious_act", act, 1'b0);
         end else begin
            got_e = sb.pop_front();
            chk("window", cur_win(), got_e.win);
            chk("win_fd", frame_done, got_e.fd);
         end
      end else if (frame_done) begin
         chk("fd_without_act", frame_done, 1'b0);
      end
      if (frame_done) fd_cnt++;
   end

   task automatic drive(input logic [7:0] v, input logic s);
      exp_t ex;
      if (s) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = v;
      if (mr >= 2 && mc >= 2) begin
         ex.win = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
                   img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
                   img[mr][mc-2],   img[mr][mc-1],   img[mr][mc]};
         ex.fd  = (mr == H - 1) && (mc == W - 1);
         sb.push_back(ex);
      end
      in_valid = 1'b1;
      in_pixel = v;
      sof      = s;
      @(posedge clk);
      #1;
      sof = 1'b0;
      mc++;
      if (mc == W) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end
   endtask

   task automatic idle();
      logic [71:0] snap;
      snap     = cur_win();
      in_valid = 1'b0;
      sof      = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_act", act, 1'b0);
      chk("idle_fd", frame_done, 1'b0);
      chk("idle_hold", cur_win(), snap);
   endtask

   task automatic send_frame(input int base, input bit gap, input bit s0);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            drive(8'(base + 4 * r + c), s0 && r == 0 && c == 0);
            if (gap) idle();
         end
      end
   endtask

   task automatic settle();
      in_valid = 1'b0;
      sof      = 1'b0;
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      sof      = 1'b0;
      in_pixel = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_act", act, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
      chk("rst_win", cur_win(), 72'h0);
`ifdef SW_FRAME_CNT_EN
      chk("rst_cnt", frame_cnt, 16'd0);
`endif
      rst_n = 1'b1;

      a0 = act_cnt;
      f0 = fd_cnt;
      send_frame(0, 0, 0);
      settle();
      chk("fill_acts", act_cnt - a0, 4);
      chk("fill_fd", fd_cnt - f0, 1);
      chk("fill_last", cur_win(), 72'h050607090a0b0d0e0f);

      a0 = act_cnt;
      f0 = fd_cnt;
      send_frame(0, 1, 0);
      settle();
      chk("gap_acts", act_cnt - a0, 4);
      chk("gap_fd", fd_cnt - f0, 1);
      chk("gap_last", cur_win(), 72'h050607090a0b0d0e0f);

      a0 = act_cnt;
      f0 = fd_cnt;
      send_frame(0, 0, 1);
`ifdef SW_FRAME_CNT_EN
      chk("cnt_three", frame_cnt, 16'd3);
`endif
      send_frame(100, 0, 1);
      settle();
      chk("b2b_acts", act_cnt - a0, 8);
      chk("b2b_fd", fd_cnt - f0, 2);
      chk("b2b_last", cur_win(), 72'h696a6b6d6e6f717273);

      a0 = act_cnt;
      f0 = fd_cnt;
      for (int k = 0; k < 9; k++) begin
         drive(8'(50 + k), 1'b0);
      end
      chk("abort_noact", act_cnt - a0, 0);
      send_frame(200, 0, 1);
      settle();
      chk("sof_acts", act_cnt - a0, 4);
      chk("sof_fd", fd_cnt - f0, 1);

      a0 = act_cnt;
      f0 = fd_cnt;
      for (int k = 0; k < 13; k++) begin
         drive(8'(150 + k), 1'b0);
      end
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_act", act, 1'b0);
      chk("mrst_fd", frame_done, 1'b0);
      chk("mrst_win", cur_win(), 72'h0);
      rst_n = 1'b1;
      mr    = 0;
      mc    = 0;
      send_frame(30, 0, 0);
      settle();
      chk("mrst_acts", act_cnt - a0, 6);
      chk("mrst_fd_cnt", fd_cnt - f0, 1);
      chk("mrst_last", cur_win(), 72'h2324252728292b2c2d);

`ifdef SW_FRAME_CNT_EN
      force dut.frame_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_cnt;
      send_frame(0, 0, 1);
      settle();
      chk("cnt_wrap", frame_cnt, 16'd0);
`endif

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
